// File: rtl/vc_test_src_pkg.sv
// rtl/vc_test_src_pkg.sv - shared types and helpers for the multi-channel delay source
package vc_test_src_pkg;

  typedef enum logic [1:0] {
    DM_NONE  = 2'd0,
    DM_RAND  = 2'd1,
    DM_FIXED = 2'd2,
    DM_PAUSE = 2'd3
  } delay_mode_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } src_state_e;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int c);
    logic [31:0] s;
    s = base ^ 32'(c);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // 33-bit modulus so a bound of all-ones yields the raw lfsr value
  function automatic logic [31:0] rand_draw(input logic [31:0] l, input logic [31:0] bound);
    logic [32:0] num;
    logic [32:0] den;
    num = {1'b0, l};
    den = {1'b0, bound} + 33'd1;
    return 32'(num % den);
  endfunction

endpackage

// File: rtl/vc_test_src_chan.sv
// rtl/vc_test_src_chan.sv - one channel: message memory, delay FSM, counter and LFSR
module vc_test_src_chan
  import vc_test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 1,
  parameter int          p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'h1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic [1:0]             delay_mode,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int IW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

  // Entry-valid flags stand in for the all-X end marker, which two-state simulators cannot see
  logic [p_msg_nbits-1:0] m     [p_num_msgs];
  logic                   m_vld [p_num_msgs];

  task automatic clear_mem();
    for (int i = 0; i < p_num_msgs; i++) m_vld[i] = 1'b0;
  endtask

  task automatic load_entry(input int i, input logic [p_msg_nbits-1:0] v);
    m[i]     = v;
    m_vld[i] = 1'b1;
  endtask

  src_state_e  state;
  logic [31:0] cnt;
  logic [31:0] lfsr;
  logic [IW-1:0] idx;

  delay_mode_e mode;
  logic [31:0] draw;
  logic        has_next;
  logic [IW-1:0] next_idx;
  logic        sched;

  assign mode = delay_mode_e'(delay_mode);

  always_comb begin
    draw = 32'h0;
    case (mode)
      DM_RAND:  draw = rand_draw(lfsr, max_delay);
      DM_FIXED: draw = max_delay;
      default:  draw = 32'h0;
    endcase
  end

  always_comb begin
    next_idx = idx;
    has_next = 1'b0;
    if (state == ST_INIT) begin
      next_idx = '0;
      has_next = m_vld[0];
    end else if (int'(idx) < p_num_msgs - 1) begin
      next_idx = idx + 1'b1;
      has_next = m_vld[next_idx];
    end
  end

  assign sched = (state == ST_INIT) || (state == ST_SEND && rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= 32'h0;
      idx   <= '0;
      lfsr  <= p_seed;
    end else begin
      lfsr <= lfsr_step(lfsr);
      case (state)
        ST_INIT, ST_SEND: begin
          if (sched) begin
            if (!has_next) begin
              state <= ST_DONE;
            end else begin
              idx <= next_idx;
              if (draw == 32'h0 && mode != DM_PAUSE) begin
                state <= ST_SEND;
              end else begin
                state <= ST_DELAY;
                cnt   <= draw;
              end
            end
          end
        end
        ST_DELAY: begin
          if (mode != DM_PAUSE) begin
            if (cnt > 32'd1) cnt <= cnt - 32'd1;
            else             state <= ST_SEND;
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

  assign val  = (state == ST_SEND);
  assign done = (state == ST_DONE);
  assign msg  = m[idx];

endmodule

// File: rtl/vc_test_multi_delay_source.sv
// rtl/vc_test_multi_delay_source.sv - multi-channel val/rdy test source with run-time delay modes
module vc_test_multi_delay_source
  import vc_test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 1,
  parameter int          p_num_msgs  = 1024,
  parameter int          p_nchan     = 1,
  parameter logic [31:0] p_seed      = 32'hB5AD4ECE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    max_delay,
  input  logic [2*p_nchan-1:0]           delay_mode,
  output logic [p_nchan-1:0]             val,
  input  logic [p_nchan-1:0]             rdy,
  output logic [p_msg_nbits*p_nchan-1:0] msg,
  output logic [p_nchan-1:0]             done,
  output logic                           all_done
);

  for (genvar c = 0; c < p_nchan; c++) begin : g_chan
    vc_test_src_chan #(
      .p_msg_nbits (p_msg_nbits),
      .p_num_msgs  (p_num_msgs),
      .p_seed      (chan_seed(p_seed, c))
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .max_delay  (max_delay),
      .delay_mode (delay_mode[2*c +: 2]),
      .val        (val[c]),
      .rdy        (rdy[c]),
      .msg        (msg[c*p_msg_nbits +: p_msg_nbits]),
      .done       (done[c])
    );
  end

  assign all_done = &done;

endmodule

// File: tb/tb_vc_test_multi_delay_source.sv
// tb/tb_vc_test_multi_delay_source.sv - randomized bench with a gap-budget reference model
module tb_vc_test_multi_delay_source;

  localparam int NC   = 3;
  localparam int NM   = 16;
  localparam int W    = 8;
  localparam int MAXK = 200;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     max_delay = 32'h0;
  logic [2*NC-1:0] delay_mode = '0;
  logic [NC-1:0]   val;
  logic [NC-1:0]   rdy = '0;
  logic [W*NC-1:0] msg;
  logic [NC-1:0]   done;
  logic            all_done;

  always #5 clk = ~clk;

  vc_test_multi_delay_source #(
    .p_msg_nbits (W),
    .p_num_msgs  (NM),
    .p_nchan     (NC),
    .p_seed      (32'hB5AD4ECE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .max_delay  (max_delay),
    .delay_mode (delay_mode),
    .val        (val),
    .rdy        (rdy),
    .msg        (msg),
    .done       (done),
    .all_done   (all_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [W-1:0] tb_mem [NC][NM];
  int           tb_n   [NC];
  logic         rdy_s  [NC][MAXK];
  logic [1:0]   mode_s [NC][MAXK];

  int rise_at  [NC][NM];
  int rise_cnt [NC];
  int done_at  [NC];
  int max_gap  [NC];
  int all_done_at;

  // Reference: each channel is either sending, waiting out an idle budget, or finished
  bit          m_send [NC];
  bit          m_wait [NC];
  bit          m_fin  [NC];
  int          m_pos  [NC];
  int          m_acc  [NC];
  longint      m_r    [NC];
  logic [31:0] m_lfsr [NC];

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = 32'hB5AD4ECE ^ 32'(c);
    return (s == 32'h0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic longint draw(input logic [1:0] md, input logic [31:0] l, input logic [31:0] mx);
    case (md)
      2'd1:    return longint'(l) % (longint'(mx) + 64'sd1);
      2'd2:    return longint'(mx);
      default: return 64'sd0;
    endcase
  endfunction

  task automatic model_reset(input int c);
    m_send[c] = 1'b0; m_wait[c] = 1'b0; m_fin[c] = 1'b0;
    m_pos[c] = 0; m_acc[c] = 0; m_r[c] = 0;
    m_lfsr[c] = seed_of(c);
  endtask

  task automatic model_sched(input int c, input int p, input logic [1:0] md);
    longint d;
    if (p < tb_n[c]) begin
      m_pos[c] = p;
      d = draw(md, m_lfsr[c], max_delay);
      if (d == 0 && md != 2'd3) m_send[c] = 1'b1;
      else begin
        m_wait[c] = 1'b1;
        m_r[c]    = (d == 0) ? 64'sd1 : d;
      end
    end else begin
      m_fin[c] = 1'b1;
    end
  endtask

  task automatic model_end(input int c, input int kl, input logic r, input logic [1:0] md);
    if (kl == 0) model_sched(c, 0, md);
    else if (m_send[c] && r) begin
      m_send[c] = 1'b0;
      m_acc[c]++;
      model_sched(c, m_pos[c] + 1, md);
    end else if (m_wait[c] && md != 2'd3) begin
      m_r[c]--;
      if (m_r[c] == 0) begin
        m_wait[c] = 1'b0;
        m_send[c] = 1'b1;
      end
    end
    m_lfsr[c] = lfsr_adv(m_lfsr[c]);
  endtask

  task automatic load_chan(input int c, input int n);
    tb_n[c] = n;
    case (c)
      0: dut.g_chan[0].u_chan.clear_mem();
      1: dut.g_chan[1].u_chan.clear_mem();
      default: dut.g_chan[2].u_chan.clear_mem();
    endcase
    for (int i = 0; i < n; i++) begin
      tb_mem[c][i] = W'($urandom);
      case (c)
        0: dut.g_chan[0].u_chan.load_entry(i, tb_mem[c][i]);
        1: dut.g_chan[1].u_chan.load_entry(i, tb_mem[c][i]);
        default: dut.g_chan[2].u_chan.load_entry(i, tb_mem[c][i]);
      endcase
    end
  endtask

  task automatic fill(input int c, input logic r, input logic [1:0] md);
    for (int k = 0; k < MAXK; k++) begin
      rdy_s[c][k]  = r;
      mode_s[c][k] = md;
    end
  endtask

  task automatic run(input int ncyc, input logic [31:0] md, input bit rst_mid);
    int  kl;
    bit  pend;
    bit  used;
    bit  exp_all;
    bit  prev_val [NC];
    bit  track    [NC];
    int  idle     [NC];
    reset = 1'b1; max_delay = md; rdy = '0; delay_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; kl = 0; pend = 1'b0; used = 1'b0; all_done_at = -1;
    for (int c = 0; c < NC; c++) begin
      model_reset(c);
      rise_cnt[c] = 0; done_at[c] = -1; max_gap[c] = 0;
      prev_val[c] = 1'b0; track[c] = 1'b0; idle[c] = 0;
    end
    for (int k = 0; k < ncyc; k++) begin
      reset = pend;
      for (int c = 0; c < NC; c++) begin
        rdy[c] = rdy_s[c][k];
        delay_mode[2*c +: 2] = mode_s[c][k];
      end
      @(negedge clk);
      exp_all = 1'b1;
      for (int c = 0; c < NC; c++) begin
        check_eq($sformatf("val%0d@%0d", c, k), val[c], m_send[c]);
        if (m_send[c]) check_eq($sformatf("msg%0d@%0d", c, k), msg[W*c +: W], tb_mem[c][m_pos[c]]);
        check_eq($sformatf("done%0d@%0d", c, k), done[c], m_fin[c]);
        exp_all = exp_all & m_fin[c];
        if (val[c] && !prev_val[c]) begin
          if (rise_cnt[c] < NM) rise_at[c][rise_cnt[c]] = kl;
          rise_cnt[c]++;
          if (track[c] && idle[c] > max_gap[c]) max_gap[c] = idle[c];
          track[c] = 1'b0;
        end
        if (!val[c] && track[c]) idle[c]++;
        if (val[c] && rdy[c]) begin track[c] = 1'b1; idle[c] = 0; end
        if (done[c]) track[c] = 1'b0;
        if (done[c] && done_at[c] < 0) done_at[c] = kl;
        prev_val[c] = val[c];
      end
      check_eq($sformatf("all_done@%0d", k), all_done, exp_all);
      if (all_done && all_done_at < 0) all_done_at = kl;
      if (pend) begin
        for (int c = 0; c < NC; c++) begin
          model_reset(c);
          track[c] = 1'b0;
        end
        kl = 0; pend = 1'b0;
      end else begin
        for (int c = 0; c < NC; c++) model_end(c, kl, rdy_s[c][k], mode_s[c][k]);
        kl++;
        if (rst_mid && !used && m_acc[0] == 1) begin pend = 1'b1; used = 1'b1; end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // back-to-back NONE stream
    for (int c = 0; c < NC; c++) fill(c, 1'b1, 2'd0);
    load_chan(0, 4); load_chan(1, 0); load_chan(2, 0);
    run(12, 32'd0, 1'b0);
    check_eq("none_rise", rise_at[0][0], 1);
    check_eq("none_burst", rise_cnt[0], 1);
    check_eq("none_done", done_at[0], 5);
    check_eq("empty_done", done_at[1], 1);
    check_eq("none_all", all_done_at, 5);

    // FIXED gaps of 3
    fill(0, 1'b1, 2'd2);
    load_chan(0, 3);
    run(20, 32'd3, 1'b0);
    check_eq("fix_r0", rise_at[0][0], 4);
    check_eq("fix_r1", rise_at[0][1], 8);
    check_eq("fix_r2", rise_at[0][2], 12);
    check_eq("fix_done", done_at[0], 13);

    // RAND with zero bound behaves like NONE
    fill(0, 1'b1, 2'd1);
    load_chan(0, 4);
    run(12, 32'd0, 1'b0);
    check_eq("r0_rise", rise_at[0][0], 1);
    check_eq("r0_burst", rise_cnt[0], 1);
    check_eq("r0_done", done_at[0], 5);

    // RAND bound 7 with random backpressure, replayed twice
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < NC; c++) begin
        rdy_s[c][k]  = ($urandom % 4) != 0;
        mode_s[c][k] = (c == 2) ? 2'd0 : 2'd1;
      end
    for (int c = 0; c < NC; c++) load_chan(c, 10);
    for (int rep = 0; rep < 2; rep++) begin
      run(150, 32'd7, 1'b0);
      for (int c = 0; c < NC; c++) begin
        check_eq($sformatf("gap_le7_%0d", c), max_gap[c] <= 7, 1);
        check_eq($sformatf("r7_fin%0d", c), done_at[c] >= 0, 1);
      end
    end

    // stall with PAUSE switched in mid-stall
    for (int k = 0; k < MAXK; k++) begin
      rdy_s[0][k]  = (k >= 6);
      mode_s[0][k] = (k >= 3 && k <= 15) ? 2'd3 : 2'd0;
    end
    fill(1, 1'b1, 2'd0); fill(2, 1'b1, 2'd0);
    load_chan(0, 3); load_chan(1, 0); load_chan(2, 0);
    run(30, 32'd0, 1'b0);
    check_eq("stall_rise0", rise_at[0][0], 1);
    check_eq("stall_rise1", rise_at[0][1], 17);
    check_eq("stall_done", done_at[0], 19);

    // three independent channels, one paused
    fill(0, 1'b1, 2'd0); fill(1, 1'b1, 2'd2);
    for (int k = 0; k < MAXK; k++) begin
      rdy_s[2][k]  = 1'b1;
      mode_s[2][k] = (k < 20) ? 2'd3 : 2'd0;
    end
    for (int c = 0; c < NC; c++) load_chan(c, 2);
    run(30, 32'd2, 1'b0);
    check_eq("mc_done0", done_at[0], 3);
    check_eq("mc_done1", done_at[1], 7);
    check_eq("mc_done2", done_at[2], 23);
    check_eq("mc_all", all_done_at, 23);

    // reset after the first accept must replay identically
    fill(0, 1'b1, 2'd1); fill(1, 1'b1, 2'd0); fill(2, 1'b1, 2'd0);
    load_chan(0, 3); load_chan(1, 0); load_chan(2, 0);
    run(50, 32'd5, 1'b1);
    check_eq("rst_fin", done_at[0] >= 0, 1);

    // fully random modes, bounds and backpressure
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < NC; c++) begin
        logic [1:0] md;
        load_chan(c, $urandom_range(0, NM));
        md = 2'd0;
        for (int k = 0; k < MAXK; k++) begin
          if (k % 8 == 0) md = (k < MAXK - 50) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
          mode_s[c][k] = md;
          rdy_s[c][k]  = ($urandom % 4) != 0;
        end
      end
      run(MAXK, 32'($urandom_range(0, 4)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
